multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 35 +++
 rtl/multicycle_alu_if.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 108 ++++++++++
 rtl/multicycle_alu.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
// Contents:
//   OP_*         4-bit operation codes
//   alu_state_e  controller state encoding (IDLE / BUSY / DONE)
//   is_iter_op   1 for the op codes handled by the iterative mul/div engine
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LUI   = 4'b0010;  // pass B through
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;  // low half of product
  localparam logic [3:0] OP_MULHU = 4'b1100;  // high half, unsigned
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;
  localparam logic [3:0] OP_RSVD  = 4'b1111;  // result 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle of the multicycle ALU.
// Handshake: the ALU samples start_i, ALU_Operation_i, A_i and B_i on a rising
// clock edge only while ready_o=1; a start_i seen while ready_o=0 is ignored.
// done_o is a one-cycle pulse marking the cycle in which ALU_Result_o and
// Zero_o first show the result of the accepted operation; both then hold
// until the next done_o.
// Signals:
//   start_i, ALU_Operation_i[3:0], A_i, B_i  requester -> ALU
//   ready_o, done_o, ALU_Result_o, Zero_o    ALU -> requester
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALU_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] ALU_Result_o;
  logic             Zero_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  ready_o, done_o, ALU_Result_o, Zero_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output ready_o, done_o, ALU_Result_o, Zero_o
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide engine, one bit per clock.
// Ports:
//   clk, reset        clock, async active-high reset
//   start_i           load operands and op, counter := WIDTH
//   op_i              OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//   a_i, b_i          operands
//   result_o          result of the step taken in this cycle (valid with valid_o)
//   valid_o           high in the cycle of the final step; the caller registers
//                     result_o on that edge
// Multiply: {hi,lo} starts as {0,B}; each step adds A into hi when lo[0]=1 and
// shifts {carry,hi,lo} right. Divide (restoring): hi is the remainder, lo the
// dividend/quotient; each step shifts the next dividend bit into hi and
// subtracts B when it fits. B=0 then naturally yields quotient all ones and
// remainder A after the full WIDTH steps.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (A) or divisor (B)
  logic             is_div_q, is_div_d;
  logic             sel_hi_q, sel_hi_d; // MULHU / REMU read the hi register

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge;
  logic             load_div;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;

    load_div  = (op_i == OP_DIVU) || (op_i == OP_REMU);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    div_rem   = div_shift[WIDTH-1:0] - opnd_q;

    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = CNT_W'(WIDTH);
      hi_d     = '0;
      lo_d     = load_div ? a_i : b_i;
      opnd_d   = load_div ? b_i : a_i;
      is_div_d = load_div;
      sel_hi_d = (op_i == OP_MULHU) || (op_i == OP_REMU);
    end else if (active_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (is_div_q) begin
        hi_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
    end
  end

  // The last step's outcome is handed out combinationally so the controller
  // can register it on the same edge the counter reaches 0.
  assign valid_o  = active_q && (cnt_q == CNT_W'(1));
  assign result_o = sel_hi_q ? hi_d : lo_d;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL/MULHU/DIVU/REMU.
// Ports:
//   clk, reset   clock, async active-high reset
//   bus          multicycle_alu_if.slave (start/op/operands in, ready/done/result/zero out)
//   dbg_state_o  current controller state
// Single-cycle ops register their result on the start edge and pulse done_o in
// the following cycle. Iterative ops take WIDTH steps in BUSY; the last step's
// result is registered on the edge that moves to DONE.
module multicycle_alu import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_alu_if.slave         bus,
  output alu_state_e              dbg_state_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] comb_res;
  logic [SHAMT_W-1:0] shamt;
  logic             iter_start;
  logic [WIDTH-1:0] iter_res;
  logic             iter_valid;

  assign shamt = bus.B_i[SHAMT_W-1:0];

  // Single-cycle operations; iterative codes fall to default and are never
  // registered from here.
  always_comb begin
    comb_res = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:  comb_res = bus.A_i + bus.B_i;
      OP_SUB:  comb_res = bus.A_i - bus.B_i;
      OP_LUI:  comb_res = bus.B_i;
      OP_OR:   comb_res = bus.A_i | bus.B_i;
      OP_SLL:  comb_res = bus.A_i << shamt;
      OP_SRL:  comb_res = bus.A_i >> shamt;
      OP_SRA:  comb_res = WIDTH'($signed(bus.A_i) >>> shamt);
      OP_AND:  comb_res = bus.A_i & bus.B_i;
      OP_XOR:  comb_res = bus.A_i ^ bus.B_i;
      OP_SLT:  comb_res = WIDTH'($signed(bus.A_i) < $signed(bus.B_i));
      OP_SLTU: comb_res = WIDTH'(bus.A_i < bus.B_i);
      default: comb_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (iter_start),
    .op_i     (bus.ALU_Operation_i),
    .a_i      (bus.A_i),
    .b_i      (bus.B_i),
    .result_o (iter_res),
    .valid_o  (iter_valid)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (is_iter_op(bus.ALU_Operation_i)) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            result_d = comb_res;
            zero_d   = (comb_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_valid) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.ready_o      = (state_q == ST_IDLE);
  assign bus.done_o       = (state_q == ST_DONE);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;
  assign dbg_state_o      = state_q;

endmodule
